ram_burst_ctrl: RTL

Burst memory controller that sits directly upstream of the 256 x 16 data RAM in the simple processor. It accepts single- or multi-word read/write requests from the control logic over a valid/ready handshake. It drives the RAM's DATA/ADDRESS/WREN inputs and absorbs the RAM's registered-input, one-cycle read latency. Read data returns as a registered, beat-tagged stream.

---
 rtl/ram_burst_ctrl.sv | 111 +++++++++++
 1 files changed

// File: rtl/ram_burst_ctrl.sv
// Burst controller in front of the 256x16 data RAM: valid/ready bursts of 1..16 words,
// with the RAM's one-cycle registered read latency absorbed into a beat-tagged read stream.
module ram_burst_ctrl #(
    parameter int WIDTH = 16,
    parameter int ADDR  = 8,
    parameter int LENW  = 4
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             REQ_VALID,
    output logic             REQ_READY,
    input  logic             REQ_WRITE,
    input  logic [ADDR-1:0]  REQ_ADDR,
    input  logic [LENW-1:0]  REQ_LEN,
    input  logic [WIDTH-1:0] WR_DATA,
    input  logic             WR_VALID,
    output logic             WR_READY,
    output logic [WIDTH-1:0] RD_DATA,
    output logic             RD_VALID,
    output logic             RD_LAST,
    output logic             DONE,
    output logic [WIDTH-1:0] RAM_DATA,
    output logic [ADDR-1:0]  RAM_ADDRESS,
    output logic             RAM_WREN,
    input  logic [WIDTH-1:0] RAM_Q
);

    typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;

    state_t           state, state_nxt;
    logic [ADDR-1:0]  cur_addr, cur_addr_nxt;
    logic [LENW-1:0]  beats_left, beats_left_nxt;
    logic             iss_v, iss_v_nxt;
    logic             iss_last, iss_last_nxt;
    logic             done_nxt;

    // RAM ports follow cur_addr/WR_DATA in every state; only WREN is gated
    assign REQ_READY   = (state == IDLE);
    assign WR_READY    = (state == WRITE);
    assign RAM_ADDRESS = cur_addr;
    assign RAM_DATA    = WR_DATA;
    assign RAM_WREN    = (state == WRITE) && WR_VALID;

    always_comb begin
        state_nxt      = state;
        cur_addr_nxt   = cur_addr;
        beats_left_nxt = beats_left;
        iss_v_nxt      = 1'b0;
        iss_last_nxt   = iss_last;
        done_nxt       = 1'b0;
        case (state)
            IDLE: begin
                if (REQ_VALID) begin
                    cur_addr_nxt   = REQ_ADDR;
                    beats_left_nxt = REQ_LEN;
                    state_nxt      = REQ_WRITE ? WRITE : READ;
                end
            end
            WRITE: begin
                if (WR_VALID) begin
                    cur_addr_nxt   = cur_addr + 1'b1;
                    beats_left_nxt = beats_left - 1'b1;
                    if (beats_left == '0) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end
                end
            end
            READ: begin
                // one address issued per cycle; the RAM returns it one cycle later
                cur_addr_nxt   = cur_addr + 1'b1;
                beats_left_nxt = beats_left - 1'b1;
                iss_v_nxt      = 1'b1;
                iss_last_nxt   = (beats_left == '0);
                if (beats_left == '0)
                    state_nxt = DRAIN;
            end
            DRAIN: begin
                state_nxt = IDLE;
                done_nxt  = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state      <= IDLE;
            cur_addr   <= '0;
            beats_left <= '0;
            iss_v      <= 1'b0;
            iss_last   <= 1'b0;
            RD_DATA    <= '0;
            RD_VALID   <= 1'b0;
            RD_LAST    <= 1'b0;
            DONE       <= 1'b0;
        end else begin
            state      <= state_nxt;
            cur_addr   <= cur_addr_nxt;
            beats_left <= beats_left_nxt;
            iss_v      <= iss_v_nxt;
            iss_last   <= iss_last_nxt;
            DONE       <= done_nxt;
            RD_VALID   <= iss_v;
            RD_LAST    <= iss_v & iss_last;
            if (iss_v)
                RD_DATA <= RAM_Q;
        end
    end

endmodule
